coin_accumulator: RTL and testbench
===================================

Name: coin_accumulator

Overview:
- Front stage of the vending controller.
- Collects 1/2/5-ruble coin pulses into a running credit.
- When credit reaches PRICE, presents the total on `summ` for exactly one cycle, with `dispense`, to the downstream change-return stage. That stage acts on totals 5, 6, 7 and 9 and returns 0, 1, 2 or 4 rubles.
- Also handles cancel/refund and rejects coins it cannot legally accept.

Parameters:
- PRICE, 5, cost of one item in rubles. Legal range 1..11 so that PRICE+4 <= 15 fits in 4 bits.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- coin_1  in  1  one-cycle pulse: 1-ruble coin inserted.
- coin_2  in  1  one-cycle pulse: 2-ruble coin inserted.
- coin_5  in  1  one-cycle pulse: 5-ruble coin inserted.
- cancel  in  1  one-cycle pulse: customer requests refund.
- summ  out  4  total paid; nonzero only in VEND; feeds the change-return stage.
- dispense  out  1  one-cycle pulse: release item.
- coin_reject  out  1  one-cycle pulse: the last coin is returned to the customer and not credited.
- refund  out  1  one-cycle pulse: return refund_amount to the customer.
- refund_amount  out  4  valid only while refund=1, else 0.
- credit  out  4  current accumulated credit, for the display.

Behaviour:
- Reset: state=IDLE, credit=0. summ, dispense, coin_reject, refund and refund_amount are all 0.
  - Reset in any state discards the accumulated credit; no refund is issued.
- States: IDLE, COLLECT, VEND, COOLDOWN, REFUND.
- Coin value v is 1, 2 or 5. Exactly one of coin_1/2/5 high is a legal coin.
  - Two or more high in the same cycle: all rejected, coin_reject=1 next cycle, credit unchanged.
- Acceptance rule, evaluated for a legal coin in IDLE/COLLECT with n = credit + v:
  - n < PRICE: credit <= n; state <= COLLECT.
  - n >= PRICE and (n - PRICE) is in {0,1,2,4}: credit <= n; state <= VEND.
  - n - PRICE == 3: change is unsupported downstream. Coin rejected: coin_reject=1 next cycle, credit unchanged.
- VEND (1 cycle, entered the cycle after the accepting coin):
  - summ = credit, dispense = 1.
  - Next state COOLDOWN; credit <= 0.
- COOLDOWN (1 cycle, while downstream returns change):
  - summ = 0.
  - Any coin pulse is rejected (coin_reject next cycle).
  - Cancel is ignored.
  - Next state IDLE.
- VEND: any coin pulse is rejected (coin_reject next cycle); cancel is ignored.
- Cancel in COLLECT:
  - Next state REFUND.
  - REFUND (1 cycle): refund=1, refund_amount = credit; credit <= 0; next state IDLE.
  - Cancel and a coin in the same cycle: cancel wins and the coin is rejected.
- Cancel in IDLE (credit=0): ignored; no refund pulse.
- Latency:
  - coin to credit update: 1 cycle.
  - accepting coin to dispense/summ: 1 cycle.
  - coin to coin_reject: 1 cycle.
- Output timing:
  - summ, dispense and refund are decoded from the registered state and credit (Moore).
  - coin_reject is a registered pulse.
- Width: credit never exceeds PRICE+4; all arithmetic is 4-bit unsigned with no wrap.

Decomposition:
- Shared package vend_pkg:
  - state enum type for this block.
  - PRICE default.
  - coin value constants (1, 2, 5).
  - supported-change constants {0,1,2,4} and a helper function change_supported(n) shared with the change-return stage.
- Sub-module coin_value_decode (combinational):
  - coin_1/2/5 -> 4-bit value v plus `illegal` (multi-hot) flag.

Test Plan:
- PRICE=5; coin_5 in IDLE -> next cycle summ=5, dispense=1; then COOLDOWN with summ=0; then IDLE with credit=0.
- coin_2, coin_2, then coin_5 -> credit 2, 4; the coin_5 is accepted; VEND summ=9, dispense=1.
- coin_1, coin_2, then coin_5 -> credit 3; coin_5 rejected (n=8): coin_reject=1, credit stays 3, no dispense.
- coin_2 then cancel -> REFUND cycle: refund=1, refund_amount=2; then credit=0 and IDLE.
- coin_1 and coin_2 high together -> coin_reject=1, credit unchanged.
  - Also: a coin in VEND or COOLDOWN -> coin_reject=1 and the coin is not credited.
  - Also: cancel+coin together in COLLECT -> refund of the old credit, coin_reject=1.
- Credit 4, then reset asserted -> next cycle credit=0, IDLE, all outputs 0, no refund.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller front stage and change-return stage.
package vend_pkg;

    // Controller states of the coin accumulator.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_VEND     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_REFUND   = 3'd4
    } acc_state_e;

    // Default item cost in rubles; PRICE+4 must stay within 4 bits.
    localparam logic [3:0] PRICE_DEFAULT = 4'd5;

    // Coin denominations.
    localparam logic [3:0] COIN_1_VAL = 4'd1;
    localparam logic [3:0] COIN_2_VAL = 4'd2;
    localparam logic [3:0] COIN_5_VAL = 4'd5;

    // Change amounts the downstream change-return stage can pay out.
    localparam logic [3:0] CHANGE_0 = 4'd0;
    localparam logic [3:0] CHANGE_1 = 4'd1;
    localparam logic [3:0] CHANGE_2 = 4'd2;
    localparam logic [3:0] CHANGE_4 = 4'd4;

    // True when the change-return stage can pay out change amount n.
    function automatic logic change_supported(input logic [3:0] n);
        return (n == CHANGE_0) || (n == CHANGE_1) ||
               (n == CHANGE_2) || (n == CHANGE_4);
    endfunction

endpackage

// File: rtl/coin_value_decode.sv
// Turns the three coin pulse lines into a ruble value and a multi-hot flag.
module coin_value_decode
    import vend_pkg::*;
(
    input  logic       coin_1,
    input  logic       coin_2,
    input  logic       coin_5,
    output logic [3:0] value_o,
    output logic       illegal_o
);

    // Decode a one-hot coin pulse; any multi-hot combination yields value 0 and illegal.
    always_comb begin
        illegal_o = (coin_1 & coin_2) | (coin_1 & coin_5) | (coin_2 & coin_5);
        if (illegal_o) begin
            value_o = 4'd0;
        end else if (coin_1) begin
            value_o = COIN_1_VAL;
        end else if (coin_2) begin
            value_o = COIN_2_VAL;
        end else if (coin_5) begin
            value_o = COIN_5_VAL;
        end else begin
            value_o = 4'd0;
        end
    end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins into credit, hands a full payment to the
// change-return stage for one cycle, and handles cancel/refund and coin rejects.
module coin_accumulator
    import vend_pkg::*;
#(
    parameter logic [3:0] PRICE = PRICE_DEFAULT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       coin_1,
    input  logic       coin_2,
    input  logic       coin_5,
    input  logic       cancel,
    output logic [3:0] summ,
    output logic       dispense,
    output logic       coin_reject,
    output logic       refund,
    output logic [3:0] refund_amount,
    output logic [3:0] credit
);

    acc_state_e state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       reject_q, reject_d;

    logic [3:0] value_s;
    logic       illegal_s;
    logic       any_coin_s;
    logic [3:0] total_s;
    logic [3:0] change_s;

    coin_value_decode u_decode (
        .coin_1    (coin_1),
        .coin_2    (coin_2),
        .coin_5    (coin_5),
        .value_o   (value_s),
        .illegal_o (illegal_s)
    );

    // Credit candidate and change it would produce; credit < PRICE here so no wrap.
    always_comb begin
        any_coin_s = coin_1 | coin_2 | coin_5;
        total_s    = credit_q + value_s;
        change_s   = total_s - PRICE;
    end

    // State, credit and reject pulse registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= 4'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Next-state, next-credit and reject decision for the current cycle.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (cancel && (state_q == ST_COLLECT)) begin
                    // Cancel wins over any coin arriving with it.
                    state_d  = ST_REFUND;
                    reject_d = any_coin_s;
                end else if (any_coin_s) begin
                    if (illegal_s) begin
                        reject_d = 1'b1;
                    end else if (total_s < PRICE) begin
                        credit_d = total_s;
                        state_d  = ST_COLLECT;
                    end else if (change_supported(change_s)) begin
                        credit_d = total_s;
                        state_d  = ST_VEND;
                    end else begin
                        // Change of 3 cannot be paid downstream; bounce the coin.
                        reject_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_VEND: begin
                state_d  = ST_COOLDOWN;
                credit_d = 4'd0;
                reject_d = any_coin_s;
            end
            ST_COOLDOWN: begin
                state_d  = ST_IDLE;
                reject_d = any_coin_s;
            end
            ST_REFUND: begin
                state_d  = ST_IDLE;
                credit_d = 4'd0;
                reject_d = any_coin_s;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = 4'd0;
                reject_d = 1'b0;
            end
        endcase
    end

    // Moore outputs decoded from the registered state and credit.
    always_comb begin
        summ          = 4'd0;
        dispense      = 1'b0;
        refund        = 1'b0;
        refund_amount = 4'd0;
        case (state_q)
            ST_VEND: begin
                summ     = credit_q;
                dispense = 1'b1;
            end
            ST_REFUND: begin
                refund        = 1'b1;
                refund_amount = credit_q;
            end
            default: begin
                summ     = 4'd0;
                dispense = 1'b0;
            end
        endcase
        coin_reject = reject_q;
        credit      = credit_q;
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with PRICE=5.
module tb_coin_accumulator;

    logic       CLK = 1'b0;
    logic       reset;
    logic       coin_1, coin_2, coin_5, cancel;
    logic [3:0] summ, refund_amount, credit;
    logic       dispense, coin_reject, refund;

    int total = 0;
    int bad   = 0;

    // Observation vector: {summ, dispense, coin_reject, refund, refund_amount, credit}
    logic [14:0] obs;
    assign obs = {summ, dispense, coin_reject, refund, refund_amount, credit};

    coin_accumulator #(.PRICE(4'd5)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .coin_1        (coin_1),
        .coin_2        (coin_2),
        .coin_5        (coin_5),
        .cancel        (cancel),
        .summ          (summ),
        .dispense      (dispense),
        .coin_reject   (coin_reject),
        .refund        (refund),
        .refund_amount (refund_amount),
        .credit        (credit)
    );

    always #5 CLK = ~CLK;

    function automatic logic [14:0] exp_v(input int s, input int d, input int r,
                                          input int f, input int a, input int c);
        logic [3:0] s4, a4, c4;
        s4 = s[3:0];
        a4 = a[3:0];
        c4 = c[3:0];
        return {s4, d[0], r[0], f[0], a4, c4};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic c1, input logic c2, input logic c5, input logic cn);
        coin_1 = c1; coin_2 = c2; coin_5 = c5; cancel = cn;
        @(posedge CLK);
        #1;
        coin_1 = 1'b0; coin_2 = 1'b0; coin_5 = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_reset;
        logic [14:0] e;
        reset = 1'b1;
        coin_1 = 1'b0; coin_2 = 1'b0; coin_5 = 1'b0; cancel = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b0;
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_vend_exact;
        logic [14:0] e;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = exp_v(5, 1, 0, 0, 0, 5);
        total++;
        if (obs !== e) begin bad++; $display("FAIL vend5_vend got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL vend5_cooldown got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL vend5_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_accum_9;
        logic [14:0] e;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 2);
        total++;
        if (obs !== e) begin bad++; $display("FAIL acc_credit2 got=%h want=%h", obs, e); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 4);
        total++;
        if (obs !== e) begin bad++; $display("FAIL acc_credit4 got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = exp_v(9, 1, 0, 0, 0, 9);
        total++;
        if (obs !== e) begin bad++; $display("FAIL acc_vend9 got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL acc_back_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_reject_change3;
        logic [14:0] e;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL ch3_credit3 got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = exp_v(0, 0, 1, 0, 0, 3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL ch3_reject got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = exp_v(0, 0, 0, 1, 3, 3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL ch3_refund3 got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL ch3_cleared got=%h want=%h", obs, e); end
    endtask

    task automatic test_cancel;
        logic [14:0] e;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = exp_v(0, 0, 0, 1, 2, 2);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_refund2 got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_after got=%h want=%h", obs, e); end
        // Credit must restart from zero after the refund.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_restart got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal;
        logic [14:0] e;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_v(0, 0, 1, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL multi_idle got=%h want=%h", obs, e); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL multi_credit1 got=%h want=%h", obs, e); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        e = exp_v(0, 0, 1, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL multi_collect got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_coins;
        logic [14:0] e;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 1, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL busy_vend got=%h want=%h", obs, e); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        e = exp_v(0, 0, 1, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL busy_cooldown got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL busy_no_refund got=%h want=%h", obs, e); end
    endtask

    task automatic test_cancel_coin;
        logic [14:0] e;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        e = exp_v(0, 0, 1, 1, 1, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_coin got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_coin_after got=%h want=%h", obs, e); end
    endtask

    task automatic test_cancel_idle;
        logic [14:0] e;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_idle got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL cancel_idle_next got=%h want=%h", obs, e); end
    endtask

    task automatic test_reset_mid;
        logic [14:0] e;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 4);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_credit4 got=%h want=%h", obs, e); end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        e = exp_v(0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_cleared got=%h want=%h", obs, e); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_no_refund got=%h want=%h", obs, e); end
        // IDLE after reset: a 1-ruble coin starts a fresh credit of 1.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_v(0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_fresh got=%h want=%h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_accum_9();
        test_reject_change3();
        test_cancel();
        test_illegal();
        test_busy_coins();
        test_cancel_coin();
        test_cancel_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
